// File: rtl/race_net_pkg.sv
// Shared definitions for the kart-race network scheduler: message geometry,
// field positions, FSM state types and the message pack/unpack helpers.
package race_net_pkg;

    localparam int MSG_W      = 48;
    localparam int MSG_DIBITS = 24;

    localparam int TAG_MSB  = 47;
    localparam int TAG_LSB  = 40;
    localparam int SEQ_MSB  = 39;
    localparam int SEQ_LSB  = 36;
    localparam int X_MSB    = 35;
    localparam int X_LSB    = 25;
    localparam int Y_MSB    = 24;
    localparam int Y_LSB    = 14;
    localparam int DIR_MSB  = 13;
    localparam int DIR_LSB  = 5;
    localparam int STAT_MSB = 4;
    localparam int STAT_LSB = 3;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_PEND = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_SHIFT = 2'd1,
        R_CHECK = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  seq;
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [1:0]  stat;
    } net_msg_t;

    function automatic logic [MSG_W-1:0] msg_pack(input net_msg_t m);
        return {m.tag, m.seq, m.x, m.y, m.dir, m.stat, 3'b000};
    endfunction

    function automatic net_msg_t msg_unpack(input logic [MSG_W-1:0] w);
        net_msg_t m;
        m.tag  = w[TAG_MSB:TAG_LSB];
        m.seq  = w[SEQ_MSB:SEQ_LSB];
        m.x    = w[X_MSB:X_LSB];
        m.y    = w[Y_MSB:Y_LSB];
        m.dir  = w[DIR_MSB:DIR_LSB];
        m.stat = w[STAT_MSB:STAT_LSB];
        return m;
    endfunction

endpackage

// File: rtl/race_net_scheduler_if.sv
// Transmit handshake and receive dibit stream between the scheduler (master)
// and the RMII transmit/receive blocks (slave).
interface race_net_scheduler_if;
    import race_net_pkg::*;

    logic             tx_valid_out;
    logic             tx_ready_in;
    logic [MSG_W-1:0] tx_msg_out;
    logic             tx_done_in;
    logic             rx_valid_in;
    logic [1:0]       rx_dibit_in;

    modport master (
        output tx_valid_out,
        output tx_msg_out,
        input  tx_ready_in,
        input  tx_done_in,
        input  rx_valid_in,
        input  rx_dibit_in
    );

    modport slave (
        input  tx_valid_out,
        input  tx_msg_out,
        output tx_ready_in,
        output tx_done_in,
        output rx_valid_in,
        output rx_dibit_in
    );

endinterface

// File: rtl/net_rx_assembler.sv
// Collects received payload dibits (MSB first) into a message word and, one
// cycle after the packet ends, flags it good (24 dibits, correct tag) or bad.
module net_rx_assembler
    import race_net_pkg::*;
#(
    parameter logic [7:0] MSG_TAG = 8'hA5
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             rx_valid_in,
    input  logic [1:0]       rx_dibit_in,
    output logic [MSG_W-1:0] rx_word_out,
    output logic             rx_good_out,
    output logic             rx_bad_out
);

    rx_state_t        rx_state_r;
    rx_state_t        rx_state_s;
    logic [MSG_W-1:0] shift_r;
    logic [4:0]       cnt_r;
    logic             check_ok_s;

    // RX state register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rx_state_r <= R_IDLE;
        end else begin
            rx_state_r <= rx_state_s;
        end
    end

    // RX next state: a dibit seen during R_CHECK begins the next packet
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            R_IDLE:  rx_state_s = rx_valid_in ? R_SHIFT : R_IDLE;
            R_SHIFT: rx_state_s = rx_valid_in ? R_SHIFT : R_CHECK;
            R_CHECK: rx_state_s = rx_valid_in ? R_SHIFT : R_IDLE;
            default: rx_state_s = R_IDLE;
        endcase
    end

    // Shift register and saturating dibit counter; count restarts at 1 outside R_SHIFT
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            shift_r <= {MSG_W{1'b0}};
            cnt_r   <= 5'd0;
        end else if (rx_valid_in) begin
            shift_r <= {shift_r[MSG_W-3:0], rx_dibit_in};
            if (rx_state_r == R_SHIFT) begin
                cnt_r <= (cnt_r == 5'd31) ? 5'd31 : cnt_r + 5'd1;
            end else begin
                cnt_r <= 5'd1;
            end
        end
    end

    assign check_ok_s = (cnt_r == 5'(MSG_DIBITS)) && (shift_r[TAG_MSB:TAG_LSB] == MSG_TAG);

    // Verdict pulses, decoded from the registered state
    always_comb begin
        rx_good_out = 1'b0;
        rx_bad_out  = 1'b0;
        if (rx_state_r == R_CHECK) begin
            rx_good_out = check_ok_s;
            rx_bad_out  = ~check_ok_s;
        end else begin
            rx_good_out = 1'b0;
            rx_bad_out  = 1'b0;
        end
    end

    assign rx_word_out = shift_r;

endmodule

// File: rtl/race_net_scheduler.sv
// Per-frame network scheduler: periodic TX snapshot/handshake, RX message
// acceptance and link timeout. NET_DUP_FILTER_EN enables duplicate-seq rejection.
module race_net_scheduler
    import race_net_pkg::*;
#(
    parameter int         TX_EVERY_N     = 1,
    parameter int         TIMEOUT_FRAMES = 30,
    parameter logic [7:0] MSG_TAG        = 8'hA5
) (
    input  logic                        clk_in,
    input  logic                        rst_in_n,
    input  logic                        vsync_in,
    input  logic                        enable_in,
    input  logic [10:0]                 player_x_in,
    input  logic [10:0]                 player_y_in,
    input  logic [8:0]                  direction_in,
    input  logic [1:0]                  game_stat_in,
    race_net_scheduler_if.master        net,
    output logic [10:0]                 opp_x_out,
    output logic [10:0]                 opp_y_out,
    output logic [8:0]                  opp_dir_out,
    output logic [1:0]                  opp_stat_out,
    output logic                        opp_update_out,
    output logic                        link_up_out,
    output logic [7:0]                  rx_err_count_out,
    output logic [7:0]                  tx_drop_count_out
);

    logic             vsync_r;
    logic             vsync_prev_r;
    logic             tick_s;
    logic [3:0]       frame_cnt_r;
    logic             slot_s;
    logic             snap_s;

    tx_state_t        tx_state_r;
    tx_state_t        tx_state_s;
    logic             tx_valid_r;
    logic [MSG_W-1:0] tx_msg_r;
    logic [3:0]       tx_seq_r;
    logic [7:0]       tx_drop_r;
    net_msg_t         snap_fields_s;

    logic [MSG_W-1:0] rx_word_s;
    logic             rx_good_s;
    logic             rx_bad_s;
    net_msg_t         rx_msg_s;
    logic             dup_s;
    logic             accept_s;
    logic             reject_s;
    logic             rx_unused_s;

    logic [10:0]      opp_x_r;
    logic [10:0]      opp_y_r;
    logic [8:0]       opp_dir_r;
    logic [1:0]       opp_stat_r;
    logic             opp_update_r;
    logic             link_up_r;
    logic [7:0]       rx_err_r;
    logic [7:0]       to_cnt_r;
    logic [8:0]       to_cnt_inc_s;
    logic             link_drop_s;

    // vsync synchroniser and edge history
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            vsync_r      <= 1'b0;
            vsync_prev_r <= 1'b0;
        end else begin
            vsync_r      <= vsync_in;
            vsync_prev_r <= vsync_r;
        end
    end

    assign tick_s = vsync_r & ~vsync_prev_r;

    // Frame divider: a TX slot is the tick on which the counter reads zero
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            frame_cnt_r <= 4'd0;
        end else if (tick_s) begin
            frame_cnt_r <= (frame_cnt_r == 4'(TX_EVERY_N - 1)) ? 4'd0 : frame_cnt_r + 4'd1;
        end
    end

    assign slot_s = tick_s & (frame_cnt_r == 4'd0);
    assign snap_s = slot_s & enable_in;

    // Snapshot of local racer state for the next message
    always_comb begin
        snap_fields_s      = '0;
        snap_fields_s.tag  = MSG_TAG;
        snap_fields_s.seq  = tx_seq_r;
        snap_fields_s.x    = player_x_in;
        snap_fields_s.y    = player_y_in;
        snap_fields_s.dir  = direction_in;
        snap_fields_s.stat = game_stat_in;
    end

    // TX state register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_state_s;
        end
    end

    // TX next state
    always_comb begin
        tx_state_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (snap_s) tx_state_s = TX_PEND;
                else        tx_state_s = TX_IDLE;
            end
            TX_PEND: begin
                if (tx_valid_r && net.tx_ready_in) tx_state_s = TX_BUSY;
                else                               tx_state_s = TX_PEND;
            end
            TX_BUSY: begin
                if (net.tx_done_in) tx_state_s = TX_IDLE;
                else                tx_state_s = TX_BUSY;
            end
            default: tx_state_s = TX_IDLE;
        endcase
    end

    // TX datapath: message capture, sequence number and dropped-slot count
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tx_valid_r <= 1'b0;
            tx_msg_r   <= {MSG_W{1'b0}};
            tx_seq_r   <= 4'd0;
            tx_drop_r  <= 8'd0;
        end else begin
            tx_valid_r <= (tx_state_s == TX_PEND);
            if (snap_s && (tx_state_r == TX_IDLE)) begin
                tx_msg_r <= msg_pack(snap_fields_s);
                tx_seq_r <= tx_seq_r + 4'd1;
            end
            if (snap_s && (tx_state_r != TX_IDLE) && (tx_drop_r != 8'hFF)) begin
                tx_drop_r <= tx_drop_r + 8'd1;
            end
        end
    end

    assign net.tx_valid_out  = tx_valid_r;
    assign net.tx_msg_out    = tx_msg_r;
    assign tx_drop_count_out = tx_drop_r;

    net_rx_assembler #(
        .MSG_TAG (MSG_TAG)
    ) u_rx (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .rx_valid_in (net.rx_valid_in),
        .rx_dibit_in (net.rx_dibit_in),
        .rx_word_out (rx_word_s),
        .rx_good_out (rx_good_s),
        .rx_bad_out  (rx_bad_s)
    );

    assign rx_msg_s     = msg_unpack(rx_word_s);
    assign rx_unused_s  = ^{rx_msg_s.tag, rx_msg_s.seq};
    assign to_cnt_inc_s = {1'b0, to_cnt_r} + 9'd1;
    assign link_drop_s  = ~accept_s & tick_s & (to_cnt_inc_s == 9'(TIMEOUT_FRAMES));

`ifdef NET_DUP_FILTER_EN
    logic       have_last_r;
    logic [3:0] last_seq_r;

    // Last accepted seq; forgotten on link loss so a fresh peer is always heard
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            have_last_r <= 1'b0;
            last_seq_r  <= 4'd0;
        end else if (accept_s) begin
            have_last_r <= 1'b1;
            last_seq_r  <= rx_msg_s.seq;
        end else if (link_drop_s) begin
            have_last_r <= 1'b0;
        end
    end

    assign dup_s = have_last_r & (rx_msg_s.seq == last_seq_r);
`else
    assign dup_s = 1'b0;
`endif

    assign accept_s = rx_good_s & ~dup_s;
    assign reject_s = rx_bad_s | (rx_good_s & dup_s);

    // Opponent state, link timeout and RX error count; accept beats a same-cycle tick
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            opp_x_r      <= 11'd0;
            opp_y_r      <= 11'd0;
            opp_dir_r    <= 9'd0;
            opp_stat_r   <= 2'd0;
            opp_update_r <= 1'b0;
            link_up_r    <= 1'b0;
            rx_err_r     <= 8'd0;
            to_cnt_r     <= 8'd0;
        end else begin
            opp_update_r <= accept_s;
            if (accept_s) begin
                opp_x_r    <= rx_msg_s.x;
                opp_y_r    <= rx_msg_s.y;
                opp_dir_r  <= rx_msg_s.dir;
                opp_stat_r <= rx_msg_s.stat;
                to_cnt_r   <= 8'd0;
                link_up_r  <= 1'b1;
            end else if (tick_s && (to_cnt_r != 8'(TIMEOUT_FRAMES))) begin
                to_cnt_r <= to_cnt_r + 8'd1;
                if (link_drop_s) link_up_r <= 1'b0;
            end
            if (reject_s && (rx_err_r != 8'hFF)) begin
                rx_err_r <= rx_err_r + 8'd1;
            end
        end
    end

    assign opp_x_out        = opp_x_r;
    assign opp_y_out        = opp_y_r;
    assign opp_dir_out      = opp_dir_r;
    assign opp_stat_out     = opp_stat_r;
    assign opp_update_out   = opp_update_r;
    assign link_up_out      = link_up_r;
    assign rx_err_count_out = rx_err_r;

endmodule
